// File: rtl/mix_seq_pkg.sv
// Shared definitions for the mixer sequencer: silence level, FSM encoding,
// default sizing and width helpers.
package mix_seq_pkg;

  // Offset-binary zero level of the audio path.
  localparam logic [7:0] SILENCE = 8'd128;

  // Default channel count and shared-mixer pipeline depth.
  localparam int NUM_CH_DEF      = 4;
  localparam int MIX_LATENCY_DEF = 3;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Width of the mixer wait counter for a given mixer latency.
  function automatic int wcnt_width(input int latency);
    return $clog2(latency + 2);
  endfunction

  // Width of a channel index; at least one bit so single-channel builds stay legal.
  function automatic int idx_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage : mix_seq_pkg

// File: rtl/mix_sequencer_lowest_set_bit.sv
// Priority encoder: index of the lowest set bit of a mask plus an any-bit flag.
module lowest_set_bit
  import mix_seq_pkg::*;
#(
  parameter int W     = NUM_CH_DEF,
  parameter int IDX_W = idx_width(NUM_CH_DEF)
) (
  input  logic [W-1:0]     mask,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // below[i] is set when some bit lower than i is set in the mask.
  logic [W-1:0] below;
  // first is the one-hot lowest set bit.
  logic [W-1:0] first;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_chain
      if (gi == 0) begin : g_base
        assign below[gi] = 1'b0;
      end else begin : g_link
        assign below[gi] = below[gi-1] | mask[gi-1];
      end
      assign first[gi] = mask[gi] & ~below[gi];
    end
  endgenerate

  assign any = |mask;

  // Encode the one-hot lowest bit into a binary index (zero when mask is empty).
  always_comb begin
    idx = '0;
    for (int i = 0; i < W; i++) begin
      if (first[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
  end

endmodule : lowest_set_bit

// File: rtl/mix_sequencer.sv
// Folds the enabled channels of one sample period through a single shared
// 2-input mixer, one pair at a time, and presents the final mix downstream.
module mix_sequencer
  import mix_seq_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int MIX_LATENCY = MIX_LATENCY_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_tick,
  input  logic [NUM_CH*8-1:0]   ch_samples,
  input  logic [NUM_CH-1:0]     ch_enable,
  output logic [7:0]            mix_a,
  output logic [7:0]            mix_b,
  input  logic [7:0]            mix_out,
  output logic [7:0]            audio_out,
  output logic                  audio_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int IDX_W  = idx_width(NUM_CH);
  localparam int WCNT_W = wcnt_width(MIX_LATENCY);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MIX_LATENCY);
  localparam logic [NUM_CH-1:0] MASK_ONE  = NUM_CH'(1);

  state_t              state;
  logic [NUM_CH-1:0]   pending;
  logic [7:0]          acc;
  logic [WCNT_W-1:0]   wcnt;

  // Live channel inputs and the per-tick snapshot, both as sample arrays.
  logic [7:0]          ch_arr [NUM_CH];
  logic [7:0]          snap   [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign ch_arr[gi] = ch_samples[8*gi +: 8];
    end
  endgenerate

  // One encoder serves both picks: enables at the tick, pending mask afterwards.
  logic [NUM_CH-1:0]   pick_mask;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic                pick_single;
  logic [NUM_CH-1:0]   pick_clear;

  assign pick_mask   = (state == IDLE) ? ch_enable : pending;
  assign pick_single = (pick_mask & (pick_mask - MASK_ONE)) == '0;
  assign pick_clear  = pick_mask & ~(MASK_ONE << pick_idx);

  lowest_set_bit #(
    .W     (NUM_CH),
    .IDX_W (IDX_W)
  ) u_pick (
    .mask (pick_mask),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign busy = (state != IDLE);

  // Capture all channel samples at an accepted tick; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst_n && (state == IDLE) && sample_tick) begin
      snap <= ch_arr;
    end
  end

  // Sequencer FSM with registered mixer operands and output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pending     <= '0;
      acc         <= SILENCE;
      wcnt        <= '0;
      mix_a       <= SILENCE;
      mix_b       <= SILENCE;
      audio_out   <= SILENCE;
      audio_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      audio_valid <= 1'b0;
      // A tick arriving while a sequence is in flight is dropped and flagged.
      overrun     <= sample_tick && (state != IDLE);

      case (state)
        IDLE: begin
          if (sample_tick) begin
            pending <= pick_clear;
            if (!pick_any) begin
              // Nothing enabled: emit silence immediately.
              audio_out   <= SILENCE;
              audio_valid <= 1'b1;
            end else if (pick_single) begin
              // One channel: pass straight through without touching the mixer.
              audio_out   <= ch_arr[pick_idx];
              audio_valid <= 1'b1;
            end else begin
              // Two or more: seed the accumulator with the lowest channel.
              acc   <= ch_arr[pick_idx];
              state <= ISSUE;
            end
          end
        end

        ISSUE: begin
          mix_a   <= acc;
          mix_b   <= snap[pick_idx];
          pending <= pick_clear;
          wcnt    <= '0;
          state   <= WAIT;
        end

        WAIT: begin
          if (wcnt == WCNT_LAST) begin
            acc <= mix_out;
            if (pending != '0) begin
              state <= ISSUE;
            end else begin
              audio_out   <= mix_out;
              audio_valid <= 1'b1;
              state       <= IDLE;
            end
          end else begin
            wcnt <= wcnt + WCNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : mix_sequencer

// File: tb/tb_mix_sequencer.sv
// Directed bench for mix_sequencer with a stub averaging mixer and a
// schedule-level reference model checked every clock.
module tb_mix_sequencer;

  localparam int NUM_CH = 4;
  localparam int LAT    = 3;
  localparam int STEP   = LAT + 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 sample_tick;
  logic [NUM_CH*8-1:0]  ch_samples;
  logic [NUM_CH-1:0]    ch_enable;
  logic [7:0]           mix_a, mix_b, mix_out;
  logic [7:0]           audio_out;
  logic                 audio_valid, busy, overrun;

  int checks = 0;
  int errors = 0;
  int n = 0;          // index of the most recent rising edge

  always #5 clk = ~clk;

  mix_sequencer #(.NUM_CH(NUM_CH), .MIX_LATENCY(LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .ch_samples  (ch_samples),
    .ch_enable   (ch_enable),
    .mix_a       (mix_a),
    .mix_b       (mix_b),
    .mix_out     (mix_out),
    .audio_out   (audio_out),
    .audio_valid (audio_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  // Stub mixer: average of the two inputs through LAT register stages.
  logic [7:0] stage [LAT];
  always @(posedge clk) begin
    stage[0] <= 8'((9'(mix_a) + 9'(mix_b)) >> 1);
    for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
  end
  assign mix_out = stage[LAT-1];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s edge=%0d actual=%0d required=%0d", name, n, act, req);
    end
  endtask

  // Reference model: from the channel list it computes every partial mix and
  // the edge each mixer step and the final result must appear on.
  bit          m_active = 0;
  int          m_T, m_D, m_k;
  int          m_part [NUM_CH];
  int          m_seq  [NUM_CH];
  int          m_res;
  int          e_out = 128, e_a = 128, e_b = 128;
  bit          e_valid = 0, e_ovr = 0;

  always @(posedge clk) begin : model
    bit tk, rn, was_busy;
    logic [NUM_CH-1:0] en;
    int cs [NUM_CH];
    int j;
    n++;
    tk = sample_tick; rn = rst_n; en = ch_enable;
    for (int i = 0; i < NUM_CH; i++) cs[i] = int'(ch_samples[8*i +: 8]);
    #1;
    if (!rn) begin
      e_out = 128; e_a = 128; e_b = 128;
      m_active = 0; e_valid = 0; e_ovr = 0;
    end else begin
      was_busy = m_active;
      e_valid = 0; e_ovr = 0;
      if (m_active) begin
        if (n > m_T && n < m_D && ((n - m_T - 1) % STEP) == 0) begin
          j = (n - m_T - 1) / STEP;
          e_a = m_part[j];
          e_b = m_seq[j+1];
        end
        if (n == m_D) begin
          e_out = m_res; e_valid = 1; m_active = 0;
        end
      end
      if (tk) begin
        if (was_busy) begin
          e_ovr = 1;
        end else begin
          m_k = 0;
          for (int i = 0; i < NUM_CH; i++) if (en[i]) begin m_seq[m_k] = cs[i]; m_k++; end
          if (m_k == 0) begin
            e_out = 128; e_valid = 1;
          end else if (m_k == 1) begin
            e_out = m_seq[0]; e_valid = 1;
          end else begin
            m_part[0] = m_seq[0];
            for (int i = 1; i < m_k; i++) m_part[i] = (m_part[i-1] + m_seq[i]) / 2;
            m_res = m_part[m_k-1];
            m_T = n; m_D = n + (m_k - 1) * STEP; m_active = 1;
          end
        end
      end
    end
    chk("audio_out",   int'(audio_out),   e_out);
    chk("audio_valid", int'(audio_valid), int'(e_valid));
    chk("busy",        int'(busy),        int'(m_active));
    chk("overrun",     int'(overrun),     int'(e_ovr));
    chk("mix_a",       int'(mix_a),       e_a);
    chk("mix_b",       int'(mix_b),       e_b);
  end

  // Drive one tick (sampled at the next edge); t returns that edge index.
  task automatic run_tick(input logic [31:0] s, input logic [3:0] e, output int t);
    @(negedge clk);
    ch_samples = s; ch_enable = e; sample_tick = 1'b1;
    t = n + 1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  // Wait (bounded) for audio_valid and pin its latency and value.
  task automatic wait_valid(input int t, input int lat, input int val, input string name);
    int seen;
    seen = -1;
    for (int i = 0; i < 40 && seen < 0; i++) begin
      if (audio_valid) seen = n;
      else @(negedge clk);
    end
    chk({name, "_latency"}, seen - t, lat);
    chk({name, "_value"}, int'(audio_out), val);
    $display("txn %s: tick edge %0d, valid edge %0d, audio_out %0d", name, t, seen, audio_out);
  endtask

  task automatic wait_edge(input int e);
    for (int i = 0; i < 100 && n < e; i++) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog edge=%0d actual=running required=finished", n);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int t, cnt, a0, b0;
    rst_n = 1'b0; sample_tick = 1'b0; ch_samples = '0; ch_enable = '0;
    repeat (3) @(negedge clk);
    chk("rst_audio_out", int'(audio_out), 128);
    chk("rst_busy",      int'(busy), 0);
    chk("rst_valid",     int'(audio_valid), 0);
    chk("rst_mix_a",     int'(mix_a), 128);
    chk("rst_mix_b",     int'(mix_b), 128);
    $display("txn reset: audio_out %0d busy %0d", audio_out, busy);
    rst_n = 1'b1;
    @(negedge clk);

    // Two channels: (200+100)/2 = 150, one mixer step.
    run_tick({8'd0, 8'd0, 8'd100, 8'd200}, 4'b0011, t);
    wait_valid(t, STEP, 150, "two_ch");

    // Four channels: 150, (150+60)/2=105, (105+20)/2=62; inputs scrambled after the tick.
    run_tick({8'd20, 8'd60, 8'd100, 8'd200}, 4'b1111, t);
    ch_samples = 32'hFFFF_FFFF; ch_enable = 4'b0000;
    wait_valid(t, 3 * STEP, 62, "four_ch");

    // Single channel passes straight through; mixer operands untouched.
    a0 = int'(mix_a); b0 = int'(mix_b);
    run_tick({8'd0, 8'd77, 8'd0, 8'd0}, 4'b0100, t);
    wait_valid(t, 0, 77, "one_ch");
    chk("one_ch_mix_a", int'(mix_a), a0);
    chk("one_ch_mix_b", int'(mix_b), b0);

    // No channel enabled gives silence.
    run_tick({8'd9, 8'd9, 8'd9, 8'd9}, 4'b0000, t);
    wait_valid(t, 0, 128, "no_ch");

    // Gapped enable: (10+250)/2=130, (130+40)/2=85.
    run_tick({8'd40, 8'd250, 8'd99, 8'd10}, 4'b1101, t);
    wait_valid(t, 2 * STEP, 85, "gap_ch");

    // Tick during a four-channel run is dropped with an overrun pulse.
    run_tick({8'd20, 8'd60, 8'd100, 8'd200}, 4'b1111, t);
    wait_edge(t + 7);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    chk("overrun_pulse", int'(overrun), 1);
    wait_valid(t, 3 * STEP, 62, "overrun_run");
    cnt = 0;
    repeat (12) begin @(negedge clk); if (audio_valid) cnt++; end
    chk("overrun_no_second_valid", cnt, 0);

    // Tick on the final WAIT edge is still dropped.
    run_tick({8'd0, 8'd0, 8'd100, 8'd200}, 4'b0011, t);
    wait_edge(t + STEP - 1);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    chk("last_edge_overrun", int'(overrun), 1);
    chk("last_edge_valid",   int'(audio_valid), 1);
    chk("last_edge_busy",    int'(busy), 0);
    $display("txn last_edge_tick: overrun %0d audio_out %0d", overrun, audio_out);
    repeat (2) @(negedge clk);

    // Reset in the middle of a sequence aborts without a valid pulse.
    run_tick({8'd20, 8'd60, 8'd100, 8'd200}, 4'b1111, t);
    wait_edge(t + 5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_audio_out", int'(audio_out), 128);
    chk("abort_busy",      int'(busy), 0);
    cnt = 0;
    repeat (15) begin @(negedge clk); if (audio_valid) cnt++; end
    chk("abort_no_valid", cnt, 0);
    $display("txn abort: audio_out %0d valid pulses %0d", audio_out, cnt);
    run_tick({8'd0, 8'd0, 8'd100, 8'd200}, 4'b0011, t);
    wait_valid(t, STEP, 150, "after_abort");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mix_sequencer
